netlist_bist_ctrl: RTL and testbench

//  Self-test harness for the team's combinational benchmark netlists (10 in / 14 out class).

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_lfsr.sv | 44 ++++
 rtl/netlist_bist_ctrl.sv | 163 ++++++++++++++++
 tb/tb_netlist_bist_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and step functions for the netlist BIST controller.
// Combinational helpers only; no state and no flow control.
// Both LFSR and MISR are right-shift Galois forms over a 32-bit working width.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] poly);
        return (state >> 1) ^ (state[0] ? poly : 32'h0);
    endfunction

    // A MISR step is an LFSR step with the response folded in.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] rsp,
                                              input logic [31:0] poly);
        return lfsr_next(sig, poly) ^ rsp;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Generic Galois LFSR/MISR register with synchronous load of SEED and step enable.
// val updates one cycle after load/en; val_nxt is the combinational next value.
// No backpressure: holds its value whenever neither load nor en is asserted.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int          W       = 10,
    parameter logic [W-1:0] POLY    = '0,
    parameter logic [W-1:0] SEED    = '0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] val,
    output logic [W-1:0] val_nxt
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = SEED;
        end else if (en) begin
            val_d = W'(misr_next(32'(val_q), 32'(din), 32'(POLY)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val     = val_q;
    assign val_nxt = val_d;

endmodule

// File: rtl/netlist_bist_ctrl.sv
// BIST harness: LFSR patterns into a combinational netlist, MISR-compacted responses.
// Run takes NUM_PAT+RSP_LAT cycles from the start edge to done.
// start is ignored while busy; no other flow control.
module netlist_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               PAT_W      = 10,
    parameter int               RSP_W      = 14,
    parameter int               NUM_PAT    = 1023,
    parameter int               RSP_LAT    = 1,
    parameter logic [PAT_W-1:0] LFSR_POLY  = 10'h240,
    parameter logic [PAT_W-1:0] LFSR_SEED  = 10'h001,
    parameter logic [RSP_W-1:0] MISR_POLY  = 14'h2C00,
    parameter logic [RSP_W-1:0] MISR_SEED  = 14'h0000,
    parameter logic [RSP_W-1:0] GOLDEN_SIG = 14'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PAT_W-1:0] pat_out,
    input  logic [RSP_W-1:0] rsp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [RSP_W-1:0] signature
);

    localparam logic [PAT_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;
    localparam logic [PAT_W-1:0] LAST_CNT = PAT_W'(NUM_PAT);
    localparam logic [PAT_W-1:0] CNT_ONE  = PAT_W'(1);

    bist_state_e      state_q, state_d;
    logic [PAT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             run_load, pat_en;
    logic             presenting, vld_out, drain_empty;
    logic [RSP_W-1:0] sig_nxt;

    assign presenting = (state_q == RUN);

    // vld_out marks the cycle whose rsp_in belongs to a presented pattern.
    if (RSP_LAT == 0) begin : g_no_pipe
        assign vld_out     = presenting;
        assign drain_empty = 1'b1;
    end else begin : g_pipe
        logic [RSP_LAT-1:0] pipe_q, pipe_d;

        always_comb pipe_d = (pipe_q << 1) | RSP_LAT'(presenting);

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign vld_out     = pipe_q[RSP_LAT-1];
        assign drain_empty = (pipe_d == '0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        run_load = 1'b0;
        pat_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = CNT_ONE;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    run_load = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    if (RSP_LAT == 0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_nxt == GOLDEN_SIG);
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    pat_en = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                // Leave on the edge that consumes the last valid response.
                if (drain_empty) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (sig_nxt == GOLDEN_SIG);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    logic [PAT_W-1:0] pat_nxt_unused;

    bist_lfsr #(
        .W       (PAT_W),
        .POLY    (LFSR_POLY),
        .SEED    (SEED_EFF),
        .RST_VAL ('0)
    ) u_pat_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (run_load),
        .en      (pat_en),
        .din     ('0),
        .val     (pat_out),
        .val_nxt (pat_nxt_unused)
    );

    bist_lfsr #(
        .W       (RSP_W),
        .POLY    (MISR_POLY),
        .SEED    (MISR_SEED),
        .RST_VAL (MISR_SEED)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load    (run_load),
        .en      (vld_out),
        .din     (rsp_in),
        .val     (signature),
        .val_nxt (sig_nxt)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Directed bench for netlist_bist_ctrl: full 1023-pattern run plus short runs at latency 0 and 3.
// Expected patterns/signatures are hand-computed constants.
// Stimulus driven on the falling edge; outputs sampled on the falling edge.
module tb_netlist_bist_ctrl;

    logic        clk;
    logic        rst;
    logic        start_f, start_s;
    logic        flip;

    logic [9:0]  pat_full, pat_l0, pat_l3;
    logic [13:0] rsp_full, rsp_l0, rsp_l3;
    logic [13:0] sig_full, sig_l0, sig_l3;
    logic        busy_full, done_full, pass_full;
    logic        busy_l0, done_l0, pass_l0;
    logic        busy_l3, done_l3, pass_l3;
    logic [9:0]  d1, d2, d3;

    int n_tests = 0;
    int n_fail  = 0;
    int bad     = 0;
    bit seen [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in netlists: identity for latency 0 (with an optional one-bit fault on
    // the last pattern), three-stage delayed identity for latency 3.
    assign rsp_full = 14'h0;
    assign rsp_l0   = {4'h0, pat_l0} ^ ((flip && pat_l0 == 10'h048) ? 14'h0001 : 14'h0000);
    assign rsp_l3   = {4'h0, d3};

    initial begin
        d1 = '0;
        d2 = '0;
        d3 = '0;
    end
    always @(posedge clk) begin
        d1 <= pat_l3;
        d2 <= d1;
        d3 <= d2;
    end

    netlist_bist_ctrl u_full (
        .clk(clk), .rst(rst), .start(start_f), .pat_out(pat_full), .rsp_in(rsp_full),
        .busy(busy_full), .done(done_full), .pass(pass_full), .signature(sig_full)
    );

    netlist_bist_ctrl #(.NUM_PAT(5), .RSP_LAT(0), .GOLDEN_SIG(14'h0580)) u_l0 (
        .clk(clk), .rst(rst), .start(start_s), .pat_out(pat_l0), .rsp_in(rsp_l0),
        .busy(busy_l0), .done(done_l0), .pass(pass_l0), .signature(sig_l0)
    );

    netlist_bist_ctrl #(.NUM_PAT(5), .RSP_LAT(3), .GOLDEN_SIG(14'h0580)) u_l3 (
        .clk(clk), .rst(rst), .start(start_s), .pat_out(pat_l3), .rsp_in(rsp_l3),
        .busy(busy_l3), .done(done_l3), .pass(pass_l3), .signature(sig_l3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_f = 1'b0;
        start_s = 1'b0;
        flip    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pat",   32'(pat_full),  32'h0);
        check_eq("rst_busy",  32'(busy_full), 32'h0);
        check_eq("rst_done",  32'(done_full), 32'h0);
        check_eq("rst_pass",  32'(pass_full), 32'h0);
        check_eq("rst_sig",   32'(sig_full),  32'h0);
        check_eq("rst_sig3",  32'(sig_l3),    32'h0);
        rst = 1'b0;

        @(negedge clk);
        start_f = 1'b1;
        start_s = 1'b1;
        for (int k = 1; k <= 1026; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_eq("p1_pat",   32'(pat_full),  32'h001);
                check_eq("p1_busy",  32'(busy_full), 32'h1);
                check_eq("p1_pat0",  32'(pat_l0),    32'h001);
            end
            if (k == 2) begin
                check_eq("p2_pat",   32'(pat_full), 32'h240);
                check_eq("p2_pat3",  32'(pat_l3),   32'h240);
            end
            if (k == 5) begin
                check_eq("p5_pat",   32'(pat_full), 32'h048);
                check_eq("l0_done5", 32'(done_l0),  32'h0);
            end
            if (k <= 1023) begin
                if (pat_full == 10'h0 || seen[pat_full]) bad++;
                seen[pat_full] = 1'b1;
            end
            if (k == 6) begin
                check_eq("l0_done6", 32'(done_l0), 32'h1);
                check_eq("l0_busy6", 32'(busy_l0), 32'h0);
                check_eq("l0_sig",   32'(sig_l0),  32'h0580);
                check_eq("l0_pass",  32'(pass_l0), 32'h1);
            end
            if (k == 8) check_eq("l3_done8", 32'(done_l3), 32'h0);
            if (k == 9) begin
                check_eq("l3_done9", 32'(done_l3), 32'h1);
                check_eq("l3_sig",   32'(sig_l3),  32'h0580);
                check_eq("l3_pass",  32'(pass_l3), 32'h1);
            end
            if (k == 1024) begin
                check_eq("full_done1024", 32'(done_full), 32'h0);
                check_eq("full_drain_busy", 32'(busy_full), 32'h1);
                check_eq("full_last_pat", 32'(pat_full),  32'h002);
            end
            if (k == 1025) begin
                check_eq("full_done1025", 32'(done_full), 32'h1);
                check_eq("full_busy1025", 32'(busy_full), 32'h0);
                check_eq("full_pass",     32'(pass_full), 32'h1);
                check_eq("full_sig",      32'(sig_full),  32'h0);
                check_eq("full_hold_pat", 32'(pat_full),  32'h002);
            end
            // start pulses while busy must be ignored
            start_f = (k == 300);
            start_s = (k == 3);
        end
        check_eq("pat_distinct_nonzero", 32'(bad), 32'h0);

        // Restart from DONE with a one-bit response fault on the last latency-0 pattern.
        flip    = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check_eq("rerun_busy", 32'(busy_l0), 32'h1);
        check_eq("rerun_done", 32'(done_l0), 32'h0);
        check_eq("rerun_pass", 32'(pass_l0), 32'h0);
        repeat (9) @(negedge clk);
        check_eq("flip_sig",   32'(sig_l0),  32'h0581);
        check_eq("flip_pass",  32'(pass_l0), 32'h0);
        check_eq("flip_done",  32'(done_l0), 32'h1);
        check_eq("rerun3_sig", 32'(sig_l3),  32'h0580);
        check_eq("rerun3_pass", 32'(pass_l3), 32'h1);
        flip = 1'b0;

        // Reset in the middle of a run.
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("mid_busy", 32'(busy_full), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy_full), 32'h0);
        check_eq("abort_done", 32'(done_full), 32'h0);
        check_eq("abort_pat",  32'(pat_full),  32'h0);
        check_eq("abort_sig",  32'(sig_full),  32'h0);
        start_f = 1'b1;
        @(negedge clk);
        check_eq("rst_wins_busy", 32'(busy_full), 32'h0);
        rst     = 1'b0;
        start_f = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy_full), 32'h0);
        check_eq("idle_pat",  32'(pat_full),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
